scope_capture_buffer: RTL and testbench

- Trigger-and-capture stage directly upstream of the VGA scope renderer in FPGA_MiniProject.
- Accepts an 8-bit sample stream and detects a level/slope trigger. Stores one screen-width record with pre-trigger history into a ping-pong (two-bank) buffer.
- Serves the renderer a stable, trigger-aligned record indexed by pixel column. Banks swap only at frame start, so the display never tears.

---
 rtl/scope_pkg.sv | 30 +++
 rtl/scope_dpram.sv | 29 ++
 rtl/scope_capture_buffer.sv | 172 +++++++++++++++++
 tb/tb_scope_capture_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture path.
//   - capture state encoding (PREFILL / ARMED / POST / DONE)
//   - default sample width and record depth
//   - modular add / subtract over the record depth, used by both the
//     trigger-start computation (write side) and the display read address.
package scope_pkg;

  localparam int SCOPE_SAMPLE_W = 8;
  localparam int SCOPE_DEPTH    = 640;

  localparam logic [1:0] ST_PREFILL = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_POST    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Both operands must already be in 0..depth-1.
  function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                          input int unsigned depth);
    int unsigned s;
    s = a + b;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

  function automatic int unsigned mod_sub(input int unsigned a, input int unsigned b,
                                          input int unsigned depth);
    return (a >= b) ? (a - b) : (a + depth - b);
  endfunction

endpackage

// File: rtl/scope_dpram.sv
// Simple dual-port sample RAM holding two record banks (2 x DEPTH words).
// Ports:
//   clock   - system clock
//   we      - write enable
//   wr_addr - {bank, row} write address
//   wr_data - sample to store
//   rd_addr - {bank, row} read address
//   rd_q    - registered read data (one-cycle latency, block-RAM friendly)
module scope_dpram #(
  parameter int W      = 8,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic            clock,
  input  logic            we,
  input  logic [ADDR_W:0] wr_addr,
  input  logic [W-1:0]    wr_data,
  input  logic [ADDR_W:0] rd_addr,
  output logic [W-1:0]    rd_q
);

  logic [W-1:0] mem [0:1][0:DEPTH-1];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr[ADDR_W]][wr_addr[ADDR_W-1:0]] <= wr_data;
    rd_q <= mem[rd_addr[ADDR_W]][rd_addr[ADDR_W-1:0]];
  end

endmodule

// File: rtl/scope_capture_buffer.sv
// Trigger-and-capture stage feeding the VGA scope renderer.
// Captures one DEPTH-sample record with PRETRIG samples of history before a
// level/slope trigger into a ping-pong buffer; the renderer reads the other
// bank, re-based so column PRETRIG is the trigger sample. Banks swap only on
// frame_start while a record is complete, so the picture never tears.
// Ports:
//   clock, reset             - clock, synchronous active-high reset
//   sample_valid/sample_data - incoming ADC stream
//   trig_level/trig_slope    - threshold and edge (1 = rising), sampled live
//   run                      - 1 = keep capturing, 0 = hold displayed record
//   frame_start              - vertical-blanking pulse from VGA timing
//   rd_addr/rd_data          - pixel-column read port, 1-cycle latency
//   frame_valid              - display bank holds a complete record
//   triggered                - capture is in POST or DONE
//   auto_fired               - (SCOPE_AUTOTRIG_EN only) last trigger was forced
// Optional feature macro: SCOPE_AUTOTRIG_EN (forced trigger after AUTO_TIMEOUT
// accepted samples in ARMED).
module scope_capture_buffer
  import scope_pkg::*;
#(
  parameter int SAMPLE_W = SCOPE_SAMPLE_W,
  parameter int DEPTH    = SCOPE_DEPTH,
  parameter int ADDR_W   = 10,
  parameter int PRETRIG  = 320
`ifdef SCOPE_AUTOTRIG_EN
  , parameter int AUTO_TIMEOUT = 65535
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_slope,
  input  logic                run,
  input  logic                frame_start,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                frame_valid,
  output logic                triggered
`ifdef SCOPE_AUTOTRIG_EN
  , output logic              auto_fired
`endif
);

  localparam int POST_N = DEPTH - PRETRIG - 1;

  logic [1:0]          state;
  logic                wbank;
  logic [ADDR_W-1:0]   wp, cnt, start, disp_start;
  logic [SAMPLE_W-1:0] prev;
  logic                prev_valid;
  logic                rd_zero;
  logic [SAMPLE_W-1:0] ram_q;
  logic [ADDR_W-1:0]   raddr;
  logic                acc, we, hit, fire;

  // Samples are ignored entirely once a record is complete.
  assign acc = sample_valid && (state != ST_DONE);
  // With no pre-trigger history the PREFILL cycle only hops to ARMED.
  assign we  = acc && !(state == ST_PREFILL && PRETRIG == 0);

  assign hit = prev_valid &&
               (trig_slope ? (prev < trig_level && sample_data >= trig_level)
                           : (prev > trig_level && sample_data <= trig_level));

  assign triggered = (state == ST_POST) || (state == ST_DONE);

`ifdef SCOPE_AUTOTRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            timeout;

  assign timeout = (to_cnt == TO_W'(AUTO_TIMEOUT));
  assign fire    = hit || timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt     <= '0;
      auto_fired <= 1'b0;
    end else begin
      if (state != ST_ARMED)  to_cnt <= '0;
      else if (acc && !fire)  to_cnt <= to_cnt + TO_W'(1);
      // A genuine edge wins over a coincident timeout.
      if (state == ST_ARMED && acc) begin
        if (hit)          auto_fired <= 1'b0;
        else if (timeout) auto_fired <= 1'b1;
      end
    end
  end
`else
  assign fire = hit;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_PREFILL;
      wbank       <= 1'b0;
      wp          <= '0;
      cnt         <= '0;
      start       <= '0;
      disp_start  <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      frame_valid <= 1'b0;
      rd_zero     <= 1'b1;
    end else begin
      rd_zero <= (int'(rd_addr) >= DEPTH);
      if (acc) begin
        prev       <= sample_data;
        prev_valid <= 1'b1;
      end
      if (we) wp <= (wp == ADDR_W'(DEPTH - 1)) ? '0 : wp + ADDR_W'(1);
      case (state)
        ST_PREFILL: begin
          if (PRETRIG == 0) begin
            state <= ST_ARMED;
            cnt   <= '0;
          end else if (acc) begin
            if (cnt == ADDR_W'(PRETRIG - 1)) begin
              state <= ST_ARMED;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ADDR_W'(1);
            end
          end
        end
        ST_ARMED: begin
          if (acc && fire) begin
            // wp is the address this trigger sample is written to.
            start <= ADDR_W'(mod_sub(32'(wp), PRETRIG, DEPTH));
            cnt   <= '0;
            state <= (POST_N == 0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (acc) begin
            if (cnt == ADDR_W'(POST_N - 1)) state <= ST_DONE;
            else                            cnt   <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          if (frame_start && run) begin
            wbank       <= ~wbank;
            disp_start  <= start;
            frame_valid <= 1'b1;
            wp          <= '0;
            cnt         <= '0;
            prev_valid  <= 1'b0;
            state       <= ST_PREFILL;
          end
        end
      endcase
    end
  end

  // Out-of-range columns read row 0 and are blanked by rd_zero.
  assign raddr = (int'(rd_addr) >= DEPTH) ? '0
               : ADDR_W'(mod_add(32'(disp_start), 32'(rd_addr), DEPTH));

  assign rd_data = rd_zero ? '0 : ram_q;

  scope_dpram #(.W(SAMPLE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clock   (clock),
    .we      (we),
    .wr_addr ({wbank, wp}),
    .wr_data (sample_data),
    .rd_addr ({~wbank, raddr}),
    .rd_q    (ram_q)
  );

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Bench for scope_capture_buffer. Reference model: a record is the DEPTH
// consecutive accepted samples centred so the trigger sample lands at column
// PRETRIG; the trigger is the first accepted sample (index >= PRETRIG) whose
// predecessor/current pair crosses the level on the chosen slope.
module tb_scope_capture_buffer;

  localparam int SW      = 8;
  localparam int DEPTH   = 640;
  localparam int AW      = 10;
  localparam int PRETRIG = 320;
  localparam int POST_N  = DEPTH - PRETRIG - 1;
`ifdef SCOPE_AUTOTRIG_EN
  localparam int AUTO_TO = 1000;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic [SW-1:0] trig_level = '0;
  logic          trig_slope = 1'b1;
  logic          run = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [SW-1:0] rd_data;
  logic          frame_valid;
  logic          triggered;
`ifdef SCOPE_AUTOTRIG_EN
  logic          auto_fired;
`endif

  int total = 0;
  int bad   = 0;
  int q[$];
  int tidx;
  int pending[DEPTH];
  int disp[DEPTH];
  bit exp_auto = 1'b0;

  always #5 clock = ~clock;

  scope_capture_buffer #(
    .SAMPLE_W(SW), .DEPTH(DEPTH), .ADDR_W(AW), .PRETRIG(PRETRIG)
`ifdef SCOPE_AUTOTRIG_EN
    , .AUTO_TIMEOUT(AUTO_TO)
`endif
  ) dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid),
    .sample_data(sample_data), .trig_level(trig_level), .trig_slope(trig_slope),
    .run(run), .frame_start(frame_start), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_valid(frame_valid), .triggered(triggered)
`ifdef SCOPE_AUTOTRIG_EN
    , .auto_fired(auto_fired)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input int p, input int c, input int lvl, input bit slope);
    return slope ? (p < lvl && c >= lvl) : (p > lvl && c <= lvl);
  endfunction

  // mode: 0 rising ramp, 1 falling ramp, 2 noise, 3 constant 50.
  // abort_post > 0 stops that many samples after the trigger (left in POST).
  task automatic capture(input int mode, input int lvl, input bit slope,
                         input bit fs_last, input int abort_post);
    int v, cur, n, steps;
    bit acc, fin;
    q.delete();
    tidx  = -1;
    v     = (mode == 1) ? 255 : 0;
    fin   = 1'b0;
    steps = 0;
    trig_level = SW'(lvl);
    trig_slope = slope;
    while (!fin && steps < 20000) begin
      @(negedge clock);
      acc          = ($urandom_range(0, 3) != 0);
      frame_start  = ($urandom_range(0, 31) == 0);
      sample_valid = acc;
      cur          = 0;
      if (acc) begin
        case (mode)
          0:       begin cur = v; v = (v + 1) % 256;   end
          1:       begin cur = v; v = (v + 255) % 256; end
          2:       cur = int'($urandom_range(0, 255));
          default: cur = 50;
        endcase
        sample_data = SW'(cur);
        q.push_back(cur);
        n = q.size() - 1;
        if (tidx < 0 && n >= PRETRIG && n >= 1 && hit(q[n-1], cur, lvl, slope)) begin
          tidx = n; exp_auto = 1'b0;
        end
`ifdef SCOPE_AUTOTRIG_EN
        else if (tidx < 0 && n - PRETRIG == AUTO_TO) begin
          tidx = n; exp_auto = 1'b1;
        end
`endif
        if (tidx >= 0 && n == tidx + POST_N) begin
          fin = 1'b1;
          frame_start = fs_last;
        end else if (abort_post > 0 && tidx >= 0 && n == tidx + abort_post) begin
          fin = 1'b1;
        end
      end
      steps++;
    end
    @(negedge clock);
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    chk("capture_in_budget", int'(fin), 1);
    chk("capture_triggered", int'(triggered), 1);
    if (fin && abort_post == 0) begin
      for (int k = 0; k < DEPTH; k++) pending[k] = q[tidx - PRETRIG + k];
`ifdef SCOPE_AUTOTRIG_EN
      chk("auto_fired", int'(auto_fired), int'(exp_auto));
`endif
    end
  endtask

  task automatic do_swap(input string tag);
    @(negedge clock);
    run = 1'b1;
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    disp = pending;
    chk({tag, "_fv"}, int'(frame_valid), 1);
    chk({tag, "_trig_clr"}, int'(triggered), 0);
  endtask

  task automatic read_at(input int a, output int val);
    @(negedge clock);
    rd_addr = AW'(a);
    @(negedge clock);
    val = int'(rd_data);
  endtask

  task automatic check_reads(input string tag);
    int a, val;
    for (int i = 0; i < 26; i++) begin
      case (i)
        0:       a = 0;
        1:       a = PRETRIG - 1;
        2:       a = PRETRIG;
        3:       a = DEPTH - 1;
        4:       a = DEPTH;
        5:       a = (1 << AW) - 1;
        default: a = int'($urandom_range(0, DEPTH + 40));
      endcase
      read_at(a, val);
      chk($sformatf("%s_rd[%0d]", tag, a), val, (a < DEPTH) ? disp[a] : 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int val;
    repeat (3) @(negedge clock);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_trig", int'(triggered), 0);
    chk("rst_rd", int'(rd_data), 0);
    reset = 1'b0;

    // Rising ramp: trigger sample 128 lands at column PRETRIG.
    capture(0, 128, 1'b1, 1'b0, 0);
    chk("ramp_fv_pre_swap", int'(frame_valid), 0);
    do_swap("ramp");
    read_at(320, val); chk("ramp_rd320", val, 128);
    read_at(319, val); chk("ramp_rd319", val, 127);
    check_reads("ramp");

    // Falling ramp; triggered holds in DONE and old record stays visible.
    capture(1, 100, 1'b0, 1'b0, 0);
    repeat (20) @(negedge clock);
    chk("fall_hold_trig", int'(triggered), 1);
    read_at(320, val); chk("fall_old_rd320", val, 128);
    do_swap("fall");
    read_at(320, val); chk("fall_rd320", val, 100);
    check_reads("fall");

    // Random noise with random level and slope.
    for (int r = 0; r < 3; r++) begin
      capture(2, int'($urandom_range(40, 215)), 1'($urandom_range(0, 1)), 1'b0, 0);
      do_swap($sformatf("noise%0d", r));
      check_reads($sformatf("noise%0d", r));
    end

    // run=0 in DONE: frame_start pulses must not swap.
    capture(2, int'($urandom_range(40, 215)), 1'($urandom_range(0, 1)), 1'b0, 0);
    run = 1'b0;
    for (int p = 0; p < 5; p++) begin
      @(negedge clock); frame_start = 1'b1;
      @(negedge clock); frame_start = 1'b0;
      repeat (3) @(negedge clock);
    end
    chk("hold_trig", int'(triggered), 1);
    chk("hold_fv", int'(frame_valid), 1);
    check_reads("hold_old");
    do_swap("hold");
    check_reads("hold_new");

    // frame_start on the final POST write is ignored.
    capture(0, 128, 1'b1, 1'b1, 0);
    chk("fslast_trig", int'(triggered), 1);
    check_reads("fslast_old");
    do_swap("fslast");
    check_reads("fslast_new");

    // Reset in POST, then a clean capture.
    capture(0, 128, 1'b1, 1'b0, 10);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    chk("postrst_fv", int'(frame_valid), 0);
    chk("postrst_trig", int'(triggered), 0);
    chk("postrst_rd", int'(rd_data), 0);
    reset = 1'b0;
    exp_auto = 1'b0;
`ifdef SCOPE_AUTOTRIG_EN
    chk("postrst_auto", int'(auto_fired), 0);
`endif
    capture(0, 128, 1'b1, 1'b0, 0);
    do_swap("postrst");
    read_at(320, val); chk("postrst_rd320", val, 128);
    check_reads("postrst");

    // Constant input below the level never crosses it.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    exp_auto = 1'b0;
`ifdef SCOPE_AUTOTRIG_EN
    capture(3, 128, 1'b1, 1'b0, 0);
    do_swap("autotrig");
    check_reads("autotrig");
`else
    trig_level = 8'd128;
    trig_slope = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      sample_valid = 1'b1;
      sample_data  = 8'd50;
      frame_start  = ((i % 97) == 0);
    end
    @(negedge clock);
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    chk("const_fv", int'(frame_valid), 0);
    chk("const_trig", int'(triggered), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
